// File: rtl/ring_monitor.sv
// Ring-counter integrity monitor: locks onto a rotating one-hot pattern,
// flags rotation faults, and counts faults and completed laps.
module ring_monitor #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned LOCK_CYCLES = 4
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_count_in,
  output logic             o_locked,
  output logic             o_err_pulse,
  output logic             o_err_sticky,
  output logic [7:0]       o_err_count,
  output logic [7:0]       o_lap_count,
  output logic [1:0]       o_state_out
);

  localparam int unsigned RUN_W = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SYNC  = 2'b01,
    ST_TRACK = 2'b10,
    ST_FAULT = 2'b11
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_prev;
  logic             r_prev_valid;
  logic [RUN_W-1:0] r_run;
  logic             r_locked;
  logic             r_err_pulse;
  logic             r_err_sticky;
  logic [7:0]       r_err_count;
  logic [7:0]       r_lap_count;

  state_t           w_state;
  logic             w_prev_valid;
  logic [RUN_W-1:0] w_run;
  logic [RUN_W-1:0] w_run_inc;
  logic             w_err_pulse;
  logic             w_err_sticky;
  logic [7:0]       w_err_count;
  logic [7:0]       w_lap_count;
  logic [WIDTH-1:0] w_expected;
  logic             w_good;

  // Next ring position is the previous sample rotated left by one.
  assign w_expected = {r_prev[WIDTH-2:0], r_prev[WIDTH-1]};
  assign w_good     = r_prev_valid && $onehot(i_count_in) && (i_count_in == w_expected);
  assign w_run_inc  = r_run + RUN_W'(1);

  // State register.
  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state;
  end

  // Next-state, run counter, error and lap bookkeeping.
  always_comb begin
    w_state      = r_state;
    w_run        = r_run;
    w_err_pulse  = 1'b0;
    w_err_sticky = r_err_sticky;
    w_err_count  = r_err_count;
    w_lap_count  = r_lap_count;
    w_prev_valid = i_enable && (r_state != ST_IDLE);

    if (!i_enable) begin
      w_state = ST_IDLE;
      w_run   = '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_state = ST_SYNC;
          w_run   = '0;
        end
        ST_SYNC: begin
          if (!w_good) begin
            w_run = '0;
          end else if (w_run_inc == RUN_W'(LOCK_CYCLES)) begin
            w_state = ST_TRACK;
            w_run   = '0;
          end else begin
            w_run = w_run_inc;
          end
        end
        ST_TRACK: begin
          if (!w_good) begin
            w_state      = ST_FAULT;
            w_err_pulse  = 1'b1;
            w_err_sticky = 1'b1;
            if (r_err_count != 8'hFF) w_err_count = r_err_count + 8'd1;
          end else if (i_count_in[0]) begin
            w_lap_count = r_lap_count + 8'd1;
          end
        end
        ST_FAULT: begin
          w_state = ST_SYNC;
          w_run   = '0;
        end
        default: w_state = ST_IDLE;
      endcase
    end

    // Clear overrides any same-cycle increment but leaves the FSM alone.
    if (i_clear) begin
      w_err_sticky = 1'b0;
      w_err_count  = 8'd0;
      w_lap_count  = 8'd0;
    end
  end

  // Sample history and registered outputs.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
      r_run        <= '0;
      r_locked     <= 1'b0;
      r_err_pulse  <= 1'b0;
      r_err_sticky <= 1'b0;
      r_err_count  <= 8'd0;
      r_lap_count  <= 8'd0;
    end else begin
      r_prev       <= i_count_in;
      r_prev_valid <= w_prev_valid;
      r_run        <= w_run;
      r_locked     <= (w_state == ST_TRACK);
      r_err_pulse  <= w_err_pulse;
      r_err_sticky <= w_err_sticky;
      r_err_count  <= w_err_count;
      r_lap_count  <= w_lap_count;
    end
  end

  assign o_locked     = r_locked;
  assign o_err_pulse  = r_err_pulse;
  assign o_err_sticky = r_err_sticky;
  assign o_err_count  = r_err_count;
  assign o_lap_count  = r_lap_count;
  assign o_state_out  = r_state;

endmodule

// File: tb/tb_ring_monitor.sv
// Directed bench for ring_monitor with a cycle reference model feeding a scoreboard.
module tb_ring_monitor;

  localparam int unsigned W = 4;
  localparam int unsigned L = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en  = 1'b0;
  logic         clr = 1'b0;
  logic [W-1:0] cin = '0;
  logic         o_locked, o_err_pulse, o_err_sticky;
  logic [7:0]   o_err_count, o_lap_count;
  logic [1:0]   o_state_out;

  always #5 clk = ~clk;

  ring_monitor #(.WIDTH(W), .LOCK_CYCLES(L)) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_enable     (en),
    .i_clear      (clr),
    .i_count_in   (cin),
    .o_locked     (o_locked),
    .o_err_pulse  (o_err_pulse),
    .o_err_sticky (o_err_sticky),
    .o_err_count  (o_err_count),
    .o_lap_count  (o_lap_count),
    .o_state_out  (o_state_out)
  );

  typedef struct {
    logic [1:0] st;
    logic       lk;
    logic       pl;
    logic       sk;
    logic [7:0] ec;
    logic [7:0] lc;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  logic [1:0]   m_st   = 2'd0;
  logic [W-1:0] m_prev = '0;
  logic         m_pv   = 1'b0;
  int           m_run  = 0;
  logic         m_pl   = 1'b0;
  logic         m_sk   = 1'b0;
  int           m_ec   = 0;
  int           m_lc   = 0;

  int           n_cmp  = 0;
  int           n_err  = 0;
  logic [W-1:0] ring   = 4'b0001;

  function automatic logic is_onehot(logic [W-1:0] v);
    return (v != '0) && ((v & (v - W'(1))) == '0);
  endfunction

  task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the reference model by one clock edge.
  task automatic model_step(logic r, logic e, logic c, logic [W-1:0] v);
    logic [1:0] old_st;
    logic       good;
    old_st = m_st;
    good   = m_pv && is_onehot(v) && (v == {m_prev[W-2:0], m_prev[W-1]});
    if (r) begin
      m_st = 2'd0; m_prev = '0; m_pv = 1'b0; m_run = 0;
      m_pl = 1'b0; m_sk = 1'b0; m_ec = 0; m_lc = 0;
      return;
    end
    m_pl = 1'b0;
    if (!e) begin
      m_st = 2'd0; m_run = 0;
    end else if (old_st == 2'd0 || old_st == 2'd3) begin
      m_st = 2'd1; m_run = 0;
    end else if (old_st == 2'd1) begin
      m_run = good ? m_run + 1 : 0;
      if (m_run == L) begin m_st = 2'd2; m_run = 0; end
    end else begin
      if (!good) begin
        m_st = 2'd3; m_pl = 1'b1; m_sk = 1'b1;
        m_ec = (m_ec < 255) ? m_ec + 1 : 255;
      end else if (v[0]) begin
        m_lc = (m_lc + 1) % 256;
      end
    end
    if (c) begin m_ec = 0; m_lc = 0; m_sk = 1'b0; end
    m_prev = v;
    m_pv   = e && (old_st != 2'd0);
  endtask

  // Drive one cycle, queue its expectation, then compare after the edge.
  task automatic drive(logic r, logic e, logic c, logic [W-1:0] v);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; clr = c; cin = v;
    model_step(r, e, c, v);
    x.st = m_st; x.lk = (m_st == 2'd2); x.pl = m_pl; x.sk = m_sk;
    x.ec = 8'(m_ec); x.lc = 8'(m_lc);
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check("state",      8'(o_state_out),  8'(x.st));
    check("locked",     8'(o_locked),     8'(x.lk));
    check("err_pulse",  8'(o_err_pulse),  8'(x.pl));
    check("err_sticky", 8'(o_err_sticky), 8'(x.sk));
    check("err_count",  o_err_count,      x.ec);
    check("lap_count",  o_lap_count,      x.lc);
  endtask

  task automatic ring_step(logic e, logic c);
    drive(1'b0, e, c, ring);
    ring = {ring[W-2:0], ring[W-1]};
  endtask

  // Step the clean ring until the model reports TRACK, with a bound.
  task automatic relock();
    int guard;
    guard = 0;
    while (m_st != 2'd2 && guard < 20) begin
      ring_step(1'b1, 1'b0);
      guard++;
    end
    n_cmp++;
    if (guard >= 20) begin
      n_err++;
      $error("FAIL relock_timeout: observed state %0d expected 2", m_st);
    end
  endtask

  initial begin
    // Reset
    drive(1'b1, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, 1'b0, '0);
    check("reset_state",  8'(o_state_out), 8'd0);
    check("reset_errcnt", o_err_count,     8'd0);

    // Clean ring locks on the sixth edge after enable
    ring = 4'b0001;
    for (int i = 0; i < 5; i++) ring_step(1'b1, 1'b0);
    check("not_locked_5", 8'(o_locked), 8'd0);
    ring_step(1'b1, 1'b0);
    check("locked_6",     8'(o_locked), 8'd1);
    check("errcnt_clean", o_err_count,  8'd0);

    // Three full rotations
    for (int i = 0; i < 12; i++) ring_step(1'b1, 1'b0);
    check("lap_3",       o_lap_count,      8'd3);
    check("sticky_none", 8'(o_err_sticky), 8'd0);

    // Multi-hot injection
    drive(1'b0, 1'b1, 1'b0, 4'b0110);
    check("inj_pulse",  8'(o_err_pulse),  8'd1);
    check("inj_state",  8'(o_state_out),  8'd3);
    check("inj_errcnt", o_err_count,      8'd1);
    check("inj_sticky", 8'(o_err_sticky), 8'd1);
    ring_step(1'b1, 1'b0);
    check("post_fault_state", 8'(o_state_out), 8'd1);
    check("post_fault_pulse", 8'(o_err_pulse), 8'd0);
    for (int i = 0; i < 3; i++) ring_step(1'b1, 1'b0);
    check("relock_3_unlocked", 8'(o_locked), 8'd0);
    ring_step(1'b1, 1'b0);
    check("relock_4_locked",   8'(o_locked), 8'd1);

    // Enable drop for two cycles, then relock
    ring_step(1'b0, 1'b0);
    ring_step(1'b0, 1'b0);
    check("dis_state",  8'(o_state_out), 8'd0);
    check("dis_locked", 8'(o_locked),    8'd0);
    check("dis_lap",    o_lap_count,     8'd3);
    check("dis_errcnt", o_err_count,     8'd1);
    for (int i = 0; i < 5; i++) ring_step(1'b1, 1'b0);
    check("reen_5_unlocked", 8'(o_locked), 8'd0);
    ring_step(1'b1, 1'b0);
    check("reen_6_locked",   8'(o_locked), 8'd1);

    // Saturate the error counter with 256 more faults
    for (int i = 0; i < 256; i++) begin
      relock();
      drive(1'b0, 1'b1, 1'b0, 4'b0000);
    end
    check("sat_errcnt", o_err_count,      8'd255);
    check("sat_sticky", 8'(o_err_sticky), 8'd1);
    ring_step(1'b1, 1'b1);
    check("clr_errcnt", o_err_count,      8'd0);
    check("clr_sticky", 8'(o_err_sticky), 8'd0);

    // Clear coincident with a fault
    relock();
    drive(1'b0, 1'b1, 1'b1, 4'b0110);
    check("clrf_pulse",  8'(o_err_pulse),  8'd1);
    check("clrf_errcnt", o_err_count,      8'd0);
    check("clrf_sticky", 8'(o_err_sticky), 8'd0);
    check("clrf_state",  8'(o_state_out),  8'd3);

    // Reset mid-TRACK with enable and clear asserted
    relock();
    for (int i = 0; i < 4; i++) ring_step(1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, ring);
    check("rst_track_state", 8'(o_state_out), 8'd0);
    check("rst_track_lap",   o_lap_count,     8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ring_monitor.md
RING_MONITOR -- requirements
Module: ring_monitor

Interface
REQ-001 Parameter WIDTH, default 4: ring width, equal to the upstream ring_counter Count_out width.
REQ-002 Parameter LOCK_CYCLES, default 4: consecutive good transitions required to declare lock.
REQ-003 Clock  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Enable  input  1  monitor enable; low forces IDLE.
REQ-006 Clear  input  1  one-cycle pulse; clears counters and sticky error.
REQ-007 Count_in  input  WIDTH  ring pattern from upstream ring_counter Count_out.
REQ-008 Locked  output  1  high while in TRACK.
REQ-009 Err_pulse  output  1  one-cycle pulse per detected fault in TRACK.
REQ-010 Err_sticky  output  1  set on any fault; held until Clear or Reset.
REQ-011 Err_count  output  8  faults detected in TRACK, saturating.
REQ-012 Lap_count  output  8  completed full rotations in TRACK, modulo 256.
REQ-013 State_out  output  2  FSM state: 00 IDLE, 01 SYNC, 10 TRACK, 11 FAULT.

Function
REQ-014 Block SHALL register Count_in each cycle into prev_q and set prev_valid=1 whenever Enable=1.
REQ-015 Expected value SHALL be rotate-left of prev_q: {prev_q[WIDTH-2:0], prev_q[WIDTH-1]} (0001->0010->0100->1000->0001).
REQ-016 A cycle is "good" when prev_valid=1, Count_in is one-hot, and Count_in equals expected; otherwise "bad" (zero, multi-hot, or wrong position).
REQ-017 All outputs SHALL be registered; an input sampled at edge N is reflected on outputs after edge N.
REQ-018 IDLE: Enable=1 -> SYNC; prev_valid cleared while in IDLE.
REQ-019 SYNC: internal good-run counter increments on good, resets to 0 on bad; reaching LOCK_CYCLES -> TRACK.
REQ-020 TRACK: bad cycle -> FAULT, Err_pulse=1 for that one cycle, Err_sticky=1, Err_count+1 (hold at 255).
REQ-021 TRACK: good cycle with Count_in[0]=1 (wrap from bit WIDTH-1) SHALL increment Lap_count, wrapping 255->0.
REQ-022 FAULT: lasts exactly one cycle, then -> SYNC with good-run counter = 0.
REQ-023 Bad cycles in SYNC SHALL NOT affect Err_pulse, Err_sticky or Err_count.
REQ-024 Enable=0 in any state -> IDLE at next edge; Locked=0; Err_count, Lap_count, Err_sticky hold.
REQ-025 Clear=1: Err_count, Lap_count, Err_sticky -> 0; FSM state unaffected.
REQ-026 Clear and fault in the same cycle: counters/sticky cleared (Clear wins); FSM still -> FAULT and Err_pulse still asserts.
REQ-027 Locked SHALL equal (State_out==TRACK).

Reset
REQ-028 Reset=1 at an edge: state IDLE, prev_q=0, prev_valid=0, good-run=0, all outputs 0.
REQ-029 Reset SHALL take priority over Enable and Clear; Reset asserted mid-TRACK returns to IDLE next edge.

Verification
REQ-030 Reset, Enable=1, clean ring 0001,0010,0100,1000,... -> Locked=1 after 4 good transitions (6th edge after Enable), Err_count=0.
REQ-031 Locked, run 3 full rotations -> Lap_count=3, Err_sticky=0.
REQ-032 Locked, inject 0110 for one cycle -> Err_pulse one cycle, State_out 11 then 01, Err_count=1, Err_sticky=1, Locked=0 until 4 further good transitions.
REQ-033 Force 256 faults (alternate lock/fault) -> Err_count holds 255; Clear -> Err_count=0, Err_sticky=0.
REQ-034 Locked, drop Enable for 2 cycles then re-raise -> IDLE, counters held, relock after 4 good transitions.
REQ-035 Clear coincident with injected fault -> Err_pulse=1, Err_count=0, Err_sticky=0, State_out=11.
